joy_serial_scan: RTL and testbench
==================================

Name: joy_serial_scan

Overview:
- Parametrised serial joystick scanner; successor to the fixed two-player DB15 shift-register reader used on the UserIO port.
- Drives a 74HC165-style chain (load, clock), deserialises any number of players and bits per player, and debounces across frames.
- Detects unplugged pads and publishes a frame strobe.
- Sits between the UserIO pins and the core's joystick muxing, in the joystick clock domain.

Parameters:
- PLAYERS, 2, number of pads on the chain (1..4).
- BITS_PER_PLAYER, 12, serial bits per pad (1..16).
- CLK_DIV, 32, clk cycles per half-period of joy_clk and per load pulse (>=2).
- IDLE_CYCLES, 256, gap between frames in clk cycles (>=1).
- DEBOUNCE, 2, consecutive identical frames required before commit (1..7).

Ports:
- clk  in  1  scan clock, 40-50 MHz.
- RESET_L  in  1  reset: asynchronous, active-low.
- enable  in  1  scanning permitted.
- joy_data  in  1  serial data from the chain; active-low buttons.
- joy_clk  out  1  shift clock to the chain.
- joy_load  out  1  parallel load to the chain, active-low.
- joystick  out  PLAYERS*16  committed state; player p occupies [16p+15:16p]; active-high; bits above BITS_PER_PLAYER are 0.
- connected  out  PLAYERS  per-pad presence.
- frame_done  out  1  one-cycle pulse on each commit evaluation.

Behaviour:
- Reset values:
  - joy_clk=1, joy_load=1, frame_done=0.
  - joystick=0, connected=0.
  - Debounce count=0, candidate=0.
  - FSM=IDLE, divider=0.
- Reset is asynchronous and may occur mid-frame. Outputs return to reset values immediately, and the partial frame is discarded.
- N = PLAYERS*BITS_PER_PLAYER.
- FSM states:
  - IDLE: joy_clk=1, joy_load=1. Count IDLE_CYCLES. Then go to LOAD if enable=1; otherwise stay in IDLE with the counter held at terminal.
  - LOAD: joy_load=0 for CLK_DIV cycles, then joy_load=1. Go to SHIFT with bit index k=0.
  - SHIFT: joy_clk=0 for CLK_DIV cycles.
    - On the last low cycle, sample joy_data. Store ~joy_data as raw bit k.
    - Then joy_clk=1 for CLK_DIV cycles and increment k.
    - After k reaches N-1 is sampled and its high phase completes, go to COMMIT.
  - COMMIT: one cycle, frame_done=1, then return to IDLE.
- Bit mapping: sample k belongs to player k/BITS_PER_PLAYER, bit k%BITS_PER_PLAYER.
- Frame period = CLK_DIV*(1+2N) + IDLE_CYCLES + 1 cycles. With defaults: 32*49 + 256 + 1 = 1825.
- Presence: in COMMIT, connected[p] = 0 if all raw bits of player p are 1 (chain floating low, impossible pad state); otherwise 1. It is updated every frame with no debounce.
- Debounce, evaluated in COMMIT:
  - If the raw frame equals the candidate, saturate-increment count (max 7).
  - Otherwise set candidate=raw and count=1.
  - When count>=DEBOUNCE, joystick := candidate, with disconnected players forced to 0.
  - With DEBOUNCE=1, every frame commits.
- enable deasserted mid-frame: the current frame completes, including COMMIT. Scanning then holds in IDLE, and outputs hold their last values.
- enable reasserted: the next frame begins within IDLE_CYCLES+1 cycles.
- joy_clk and joy_load are registered outputs; no combinational path from inputs.

Optional Feature:
- Macro: JOY_SCAN_SOCD_EN.
- Defined: at commit, per player:
  - If bit3 (up) and bit2 (down) are both 1, both are cleared.
  - If bit1 (left) and bit0 (right) are both 1, both are cleared.
  - Applied after disconnect forcing.
  - Only effective when BITS_PER_PLAYER>=4.
- Undefined: bits 0-3 pass unaltered; no extra logic is generated.

Test Plan:
- Reset mid-SHIFT (k=5), then release with enable=1 → joy_clk=1, joy_load=1, joystick=0 during reset; first joy_load low exactly IDLE_CYCLES=256 cycles after release; first frame_done 1825 cycles after release.
- Defaults; chain model drives player0 bit0 low (right) and player1 bit8 low; DEBOUNCE=2 → frame_done #1 leaves joystick=0; at frame_done #2, joystick[0]=1, joystick[24]=1, all others 0; connected=2'b11.
- Glitch: one frame shows player0 bit4 asserted between clean frames → joystick[4] never rises; debounce count restarts and the next clean-frame commit occurs one frame later.
- Player1 all 12 bits read low (joy_data=0) for 2 frames → connected=2'b01; joystick[31:16]=0; player0 unaffected.
- enable dropped during SHIFT → the frame finishes with one frame_done; then joy_load and joy_clk stay 1 for 10000 cycles; reassert → LOAD within 257 cycles.
- JOY_SCAN_SOCD_EN, PLAYERS=1, BITS_PER_PLAYER=8, up+down+left held → committed joystick[3:0]=4'b0010.

Source files
------------

// File: rtl/joy_serial_scan.sv
// joy_serial_scan: 74HC165 chain scanner with cross-frame debounce, presence detect and frame strobe.
// Optional JOY_SCAN_SOCD_EN clears opposing up/down and left/right pairs at commit.
module joy_serial_scan #(
    parameter int PLAYERS         = 2,
    parameter int BITS_PER_PLAYER = 12,
    parameter int CLK_DIV         = 32,
    parameter int IDLE_CYCLES     = 256,
    parameter int DEBOUNCE        = 2
) (
    input  logic                    clk,
    input  logic                    RESET_L,
    input  logic                    enable,
    input  logic                    joy_data,
    output logic                    joy_clk,
    output logic                    joy_load,
    output logic [PLAYERS*16-1:0]   joystick,
    output logic [PLAYERS-1:0]      connected,
    output logic                    frame_done
);
    localparam int N    = PLAYERS * BITS_PER_PLAYER;
    localparam int CMAX = IDLE_CYCLES > CLK_DIV ? IDLE_CYCLES : CLK_DIV;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int KW   = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [KW-1:0] k, k_n;
    logic ph, ph_n;
    logic [N-1:0] raw, cand;
    logic [2:0] dcnt, dcnt_n;
    logic [PLAYERS-1:0] conn_n;
    logic [PLAYERS*16-1:0] joy_n;
    logic div_end;
    assign div_end = cnt == CW'(CLK_DIV - 1);
    // ph=0 is the low half of joy_clk, ph=1 the high half
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        k_n     = k;
        ph_n    = ph;
        case (state)
            IDLE: if (cnt == CW'(IDLE_CYCLES - 1)) begin
                cnt_n = cnt;
                if (enable) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end
            end
            LOAD: if (div_end) begin
                state_n = SHIFT;
                cnt_n   = '0;
                k_n     = '0;
                ph_n    = 1'b0;
            end
            SHIFT: if (div_end) begin
                cnt_n = '0;
                ph_n  = !ph;
                if (ph) begin
                    k_n = k + KW'(1);
                    if (k == KW'(N - 1)) state_n = COMMIT;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end
    // An all-pressed pad is impossible; it means the line is floating low
    always_comb begin
        dcnt_n = raw != cand ? 3'd1 : dcnt == 3'd7 ? dcnt : dcnt + 3'd1;
        conn_n = '0;
        joy_n  = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            conn_n[p] = ~&raw[p*BITS_PER_PLAYER +: BITS_PER_PLAYER];
            joy_n[p*16 +: 16] = conn_n[p] ? 16'(raw[p*BITS_PER_PLAYER +: BITS_PER_PLAYER]) : 16'd0;
`ifdef JOY_SCAN_SOCD_EN
            if (BITS_PER_PLAYER >= 4) begin
                if (joy_n[p*16+3] && joy_n[p*16+2]) joy_n[p*16+2 +: 2] = 2'b00;
                if (joy_n[p*16+1] && joy_n[p*16]) joy_n[p*16 +: 2] = 2'b00;
            end
`endif
        end
    end
    // Sample k enters at the top and has reached raw[k] after all N shifts
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state      <= IDLE;
            cnt        <= '0;
            k          <= '0;
            ph         <= 1'b0;
            raw        <= '0;
            cand       <= '0;
            dcnt       <= '0;
            joystick   <= '0;
            connected  <= '0;
            joy_clk    <= 1'b1;
            joy_load   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            k          <= k_n;
            ph         <= ph_n;
            joy_clk    <= !(state_n == SHIFT && !ph_n);
            joy_load   <= state_n != LOAD;
            frame_done <= state_n == COMMIT;
            if (state == SHIFT && !ph && div_end) raw <= N'({~joy_data, raw} >> 1);
            if (state == COMMIT) begin
                cand      <= raw;
                dcnt      <= dcnt_n;
                connected <= conn_n;
                if (dcnt_n >= 3'(DEBOUNCE)) joystick <= joy_n;
            end
        end
    end
endmodule

// File: tb/tb_joy_serial_scan.sv
// tb_joy_serial_scan: chain model feeds pad patterns; a scoreboard queue holds each loaded frame until its commit.
module tb_joy_serial_scan;
    logic        clk = 1'b0;
    logic        RESET_L = 1'b0;
    logic        enable = 1'b1;
    logic        joy_data, joy_clk, joy_load, frame_done;
    logic [31:0] joystick;
    logic [1:0]  connected;
    logic        joy_data1, joy_clk1, joy_load1, fd1;
    logic [15:0] js1;
    logic [0:0]  conn1;
    int checks = 0;
    int failures = 0;
    logic [23:0] pad = '0;
    logic [23:0] sr = '1;
    logic [7:0]  sr1 = '1;
    logic [23:0] sb_q[$];
    logic [23:0] m_cand = '0;
    int          m_cnt = 0;
    logic [31:0] m_joy = '0;
    logic [1:0]  m_conn = '0;

    joy_serial_scan u_dut (
        .clk(clk), .RESET_L(RESET_L), .enable(enable), .joy_data(joy_data),
        .joy_clk(joy_clk), .joy_load(joy_load), .joystick(joystick),
        .connected(connected), .frame_done(frame_done)
    );

    joy_serial_scan #(.PLAYERS(1), .BITS_PER_PLAYER(8), .CLK_DIV(2), .IDLE_CYCLES(4), .DEBOUNCE(1)) u_small (
        .clk(clk), .RESET_L(RESET_L), .enable(1'b1), .joy_data(joy_data1),
        .joy_clk(joy_clk1), .joy_load(joy_load1), .joystick(js1),
        .connected(conn1), .frame_done(fd1)
    );

    always #10 clk = ~clk;

    // 74HC165 model: parallel load while load is low, shift on rising shift clock
    always @(posedge joy_clk or negedge joy_load)
        if (!joy_load) begin
            sr <= ~pad;
            sb_q.push_back(pad);
        end else sr <= sr >> 1;
    assign joy_data = sr[0];

    always @(posedge joy_clk1 or negedge joy_load1)
        if (!joy_load1) sr1 <= ~8'h0e;
        else sr1 <= sr1 >> 1;
    assign joy_data1 = sr1[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pops the frame loaded for this commit and checks outputs after the commit edge
    task automatic score(input string tag);
        logic [23:0] raw;
        while (frame_done) @(negedge clk);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        raw = sb_q.pop_front();
        m_cnt = (raw == m_cand) ? (m_cnt < 7 ? m_cnt + 1 : 7) : 1;
        m_cand = raw;
        for (int p = 0; p < 2; p++) m_conn[p] = raw[p*12 +: 12] != 12'hfff;
        if (m_cnt >= 2)
            for (int p = 0; p < 2; p++) m_joy[p*16 +: 16] = m_conn[p] ? {4'h0, raw[p*12 +: 12]} : 16'h0;
        chk({tag, "_joy"}, joystick, m_joy);
        chk({tag, "_conn"}, 32'(connected), 32'(m_conn));
    endtask

    task automatic frame(input string tag, input logic [23:0] p, output int n);
        pad = p;
        n = 0;
        while (!frame_done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) chk({tag, "_timeout"}, 0, 1);
        else score(tag);
    endtask

    initial begin
        int n, m, bad;
        repeat (5) @(negedge clk);
        chk("rst_outs", {joy_clk, joy_load, frame_done, connected}, 5'b11000);
        chk("rst_joy", joystick, 0);
        RESET_L = 1'b1;
        repeat (618) @(negedge clk);
        chk("in_shift_k5", {joy_clk, joy_load}, 2'b01);
        #3 RESET_L = 1'b0;
        #1;
        chk("async_rst_outs", {joy_clk, joy_load, frame_done, connected}, 5'b11000);
        chk("async_rst_joy", joystick, 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        RESET_L = 1'b1;
        n = 0;
        while (joy_load && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        chk("first_load", n, 256);
        m = 0;
        while (!frame_done && m < 4000) begin
            @(posedge clk);
            #1 m++;
        end
        chk("load_to_frame_done", m, 32 * 49);
        score("f0");
        frame("f1", 24'h0, n);
        chk("frame_period", n + 1, 1825);
        frame("db1", 24'h100001, n);
        chk("db1_joy", joystick, 0);
        frame("db2", 24'h100001, n);
        chk("db2_joy", joystick, 32'h0100_0001);
        chk("db2_conn", 32'(connected), 3);
        frame("gl0", 24'h000002, n);
        frame("gl1", 24'h000012, n);
        chk("gl1_bit4", 32'(joystick[4]), 0);
        frame("gl2", 24'h000002, n);
        chk("gl2_nocommit", joystick, 32'h0100_0001);
        frame("gl3", 24'h000002, n);
        chk("gl3_commit", joystick, 32'h0000_0002);
        frame("dc1", 24'hfff001, n);
        chk("dc1_conn", 32'(connected), 1);
        frame("dc2", 24'hfff001, n);
        chk("dc2_joy", joystick, 32'h0000_0001);
        pad = 24'h100001;
        n = 0;
        while (joy_load && n < 4000) begin
            @(negedge clk);
            n++;
        end
        while (joy_clk && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("en_reach_shift", n < 4000, 1);
        enable = 1'b0;
        frame("en_drop", 24'h100001, n);
        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (!joy_load || !joy_clk || frame_done) bad++;
        end
        chk("en_hold_idle", bad, 0);
        enable = 1'b1;
        n = 0;
        while (joy_load && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        chk("en_resume", n >= 1 && n <= 257, 1);
        frame("en_after", 24'h100001, n);
        chk("en_after_joy", joystick, 32'h0100_0001);
        @(negedge clk);
`ifdef JOY_SCAN_SOCD_EN
        chk("small_socd", 32'(js1), 32'h0002);
`else
        chk("small_socd", 32'(js1), 32'h000e);
`endif
        chk("small_conn", 32'(conn1), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(200000 * 20);
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
